// File: rtl/eth100_pkg.sv
// eth100_pkg: shared constants and types for the 100Base MII receive/transmit paths.
package eth100_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} rx_state_e;
    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB = 4'hD;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam int ERR_LEN = 3;
    localparam int ERR_RUNT = 2;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_RXER = 0;
endpackage

// File: rtl/crc32_nib_step.sv
// crc32_nib_step: reflected CRC-32 advanced by one nibble, LSB first.
module crc32_nib_step
    import eth100_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 4; i++)
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ nib[i]) ? CRC32_POLY_REFL : 32'h0);
    end
endmodule

// File: rtl/mii_rx_100base.sv
// mii_rx_100base: MII nibble receiver; strips preamble/SFD, assembles bytes,
// checks the CRC-32 residue and reports per-frame status.
module mii_rx_100base
    import eth100_pkg::*;
#(
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518,
    parameter int MAX_PREAMBLE = 15
) (
    input  logic        clk_25Mz,
    input  logic        reset,
    input  logic        RX_DV,
    input  logic        RX_ER,
    input  logic [3:0]  RXD,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        crc_ok,
    output logic [3:0]  frame_err,
    output logic [15:0] byte_cnt,
    output logic        check_receive
);
    localparam logic [15:0] MIN_B = 16'(MIN_BYTES);
    localparam logic [15:0] MAX_B1 = 16'(MAX_BYTES + 1);
    localparam logic [7:0] MAX_PRE = 8'(MAX_PREAMBLE);

    rx_state_e   state_q, state_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  low_q, low_d;
    logic        phase_q, phase_d;
    logic [31:0] crc_q, crc_d, crc_nxt;
    logic        rx_er_q, rx_er_d;
    logic        len_err_q, len_err_d;
    logic        data_drop_q, data_drop_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        crc_ok_q, crc_ok_d;
    logic [3:0]  frame_err_q, frame_err_d;
    logic [15:0] byte_cnt_q, byte_cnt_d, next_cnt;
    logic        check_q, check_d;
    logic        fall;

    crc32_nib_step u_crc (.crc_in(crc_q), .nib(RXD), .crc_out(crc_nxt));

    always_comb begin
        state_d = state_q;
        pre_cnt_d = pre_cnt_q;
        low_d = low_q;
        phase_d = phase_q;
        crc_d = crc_q;
        rx_er_d = rx_er_q;
        len_err_d = len_err_q;
        data_drop_d = data_drop_q;
        rx_byte_d = rx_byte_q;
        valid_d = 1'b0;
        sof_d = 1'b0;
        eof_d = 1'b0;
        crc_ok_d = crc_ok_q;
        frame_err_d = frame_err_q;
        byte_cnt_d = byte_cnt_q;
        check_d = check_q;
        next_cnt = byte_cnt_q + 16'd1;
        fall = !RX_DV && (state_q == ST_DATA || (state_q == ST_DROP && data_drop_q));
        case (state_q)
            ST_IDLE: if (RX_DV) begin
                state_d = (RXD == PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
                pre_cnt_d = 8'd1;
                data_drop_d = 1'b0;
            end
            ST_PREAMBLE:
                if (!RX_DV) state_d = ST_IDLE;
                else if (RXD == PREAMBLE_NIB) begin
                    pre_cnt_d = pre_cnt_q + 8'd1;
                    if (pre_cnt_q >= MAX_PRE) state_d = ST_DROP;
                end else if (RXD == SFD_NIB) begin
                    state_d = ST_DATA;
                    byte_cnt_d = 16'd0;
                    crc_d = CRC32_INIT;
                    phase_d = 1'b0;
                    rx_er_d = 1'b0;
                    len_err_d = 1'b0;
                end else state_d = ST_DROP;
            ST_DATA: if (RX_DV) begin
                crc_d = crc_nxt;
                rx_er_d = rx_er_q | RX_ER;
                phase_d = ~phase_q;
                low_d = phase_q ? low_q : RXD;
                if (phase_q) begin
                    byte_cnt_d = next_cnt;
                    // The byte that overflows the limit is counted but never delivered.
                    if (next_cnt == MAX_B1) begin
                        len_err_d = 1'b1;
                        state_d = ST_DROP;
                        data_drop_d = 1'b1;
                    end else begin
                        rx_byte_d = {RXD, low_q};
                        valid_d = 1'b1;
                        sof_d = byte_cnt_q == 16'd0;
                    end
                end
            end
            ST_DROP: if (!RX_DV) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (fall) begin
            state_d = ST_IDLE;
            eof_d = 1'b1;
            frame_err_d = {len_err_q, byte_cnt_q < MIN_B, phase_q, rx_er_q};
            crc_ok_d = crc_q == CRC32_RESIDUE && !phase_q;
            check_d = check_q | (crc_ok_d && frame_err_d == 4'd0);
        end
    end

    always_ff @(posedge clk_25Mz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pre_cnt_q <= '0;
            low_q <= '0;
            phase_q <= 1'b0;
            crc_q <= CRC32_INIT;
            rx_er_q <= 1'b0;
            len_err_q <= 1'b0;
            data_drop_q <= 1'b0;
            rx_byte_q <= '0;
            valid_q <= 1'b0;
            sof_q <= 1'b0;
            eof_q <= 1'b0;
            crc_ok_q <= 1'b0;
            frame_err_q <= '0;
            byte_cnt_q <= '0;
            check_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_cnt_q <= pre_cnt_d;
            low_q <= low_d;
            phase_q <= phase_d;
            crc_q <= crc_d;
            rx_er_q <= rx_er_d;
            len_err_q <= len_err_d;
            data_drop_q <= data_drop_d;
            rx_byte_q <= rx_byte_d;
            valid_q <= valid_d;
            sof_q <= sof_d;
            eof_q <= eof_d;
            crc_ok_q <= crc_ok_d;
            frame_err_q <= frame_err_d;
            byte_cnt_q <= byte_cnt_d;
            check_q <= check_d;
        end
    end

    assign rx_byte = rx_byte_q;
    assign rx_byte_valid = valid_q;
    assign rx_sof = sof_q;
    assign rx_eof = eof_q;
    assign crc_ok = crc_ok_q;
    assign frame_err = frame_err_q;
    assign byte_cnt = byte_cnt_q;
    assign check_receive = check_q;
endmodule
